reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 116 +++++++++++
 tb/tb_reg_dump_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks all 2**D registers through a combinational read
// port and streams each value out on a valid/ready handshake, accumulating an XOR checksum.
// Optional build macro REG_DUMP_SKIP_ZERO_EN: zero-valued registers are not sent.
module reg_dump_reader #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         CLK,
  input  logic         init_n,
  input  logic         start,
  output logic [D-1:0] rf_addr,
  input  logic [W-1:0] rf_data,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [D-1:0] LAST_IDX = '1;

  state_e       state_q;
  logic [D-1:0] idx_q;
  logic [W-1:0] out_data_q;
  logic [D-1:0] out_addr_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] chk_q;
  logic         skip_word;

`ifdef REG_DUMP_SKIP_ZERO_EN
  assign skip_word = (rf_data == '0);
`else
  assign skip_word = 1'b0;
`endif

  // NOTE: every state bit, including the output data/address registers, is cleared by the
  // async reset so an aborted dump leaves no stale word visible; all updates use <=.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q   <= '0;
            chk_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (skip_word) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            out_data_q  <= rf_data;
            out_addr_q  <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            chk_q       <= chk_q ^ out_data_q;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The read address is the index register itself, so it moves only on clock edges.
  assign rf_addr   = idx_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = chk_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected words are queued when a dump is started
// and popped as the DUT hands words over.
module tb_reg_dump_reader;
  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 1 << D;

  typedef struct packed {
    logic [D-1:0] a;
    logic [W-1:0] d;
  } word_t;

  logic         CLK = 1'b0;
  logic         init_n = 1'b0;
  logic         start = 1'b0;
  logic [D-1:0] rf_addr;
  logic [W-1:0] rf_data;
  logic [W-1:0] out_data;
  logic [D-1:0] out_addr;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] checksum;

  logic [W-1:0] regs [N];
  word_t        sb [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int words_seen = 0;
  int last_hs = 0;
  int ready_mode = 0;
  int stall = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d;
  logic [D-1:0] hold_a;

  reg_dump_reader #(.W(W), .D(D)) dut (
    .CLK      (CLK),
    .init_n   (init_n),
    .start    (start),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 CLK = ~CLK;

  assign rf_data = regs[rf_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Ready driver: mode 0 holds ready high, mode 1 stalls each word for 5 cycles.
  always @(posedge CLK) begin
    #1;
    if (ready_mode == 0) begin
      out_ready = 1'b1;
    end else if (!out_valid) begin
      out_ready = 1'b0;
      stall = 0;
    end else if (stall < 5) begin
      out_ready = 1'b0;
      stall++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: stall stability, scoreboard pops, word spacing, done pulses.
  always @(negedge CLK) begin
    word_t e;
    if (done) done_cnt++;
    if (hold_v && out_valid) begin
      check("stall_data", out_data, hold_d);
      check("stall_addr", out_addr, hold_a);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_a = out_addr;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("extra_word", 1, 0);
      end else begin
        e = sb.pop_front();
        check("word_addr", out_addr, e.a);
        check("word_data", out_data, e.d);
      end
      if (ready_mode == 0 && words_seen > 0) check("word_gap", cyc - last_hs, 2);
      last_hs = cyc;
      words_seen++;
    end
  end

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic load_expected(output logic [W-1:0] cs, output int n);
    cs = '0;
    n  = 0;
    for (int i = 0; i < N; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (regs[i] == '0) continue;
`endif
      sb.push_back('{a: D'(i), d: regs[i]});
      cs ^= regs[i];
      n++;
    end
  endtask

  task automatic run_dump(input string tag, input int mode, input bit restart);
    logic [W-1:0] exp_cs;
    int  exp_n;
    bit  got_done = 1'b0;
    bit  restarted = 1'b0;
    ready_mode = mode;
    sb.delete();
    load_expected(exp_cs, exp_n);
    done_cnt   = 0;
    words_seen = 0;
    pulse_start();
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (restart && !restarted && words_seen >= 4) begin
        restarted = 1'b1;
        pulse_start();
      end
    end
    if (!got_done) check({tag, "_timeout"}, 0, 1);
    @(negedge CLK);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    repeat (3) @(negedge CLK);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_words"}, words_seen, exp_n);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_checksum"}, checksum, exp_cs);
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = '0;
    #13;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", checksum, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", out_addr, 0);
    check("rst_rfaddr", rf_addr, 0);
    init_n = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_hold", busy, 0);

    // Ascending pattern, ready held high.
    for (int i = 0; i < N; i++) regs[i] = W'(i * 8'h11);
    run_dump("asc", 0, 1'b0);
    check("asc_cs_const", checksum, 8'h00);

    // Single nonzero register with stalls.
    for (int i = 0; i < N; i++) regs[i] = '0;
    regs[3] = 8'hA5;
    run_dump("stall", 1, 1'b0);
    check("stall_cs_const", checksum, 8'hA5);

    // Start pulsed again mid-dump is ignored.
    for (int i = 0; i < N; i++) regs[i] = W'(i * 8'h11);
    run_dump("restart", 0, 1'b1);

    // Async reset during SEND of word 2.
    ready_mode = 1;
    sb.delete();
    begin
      logic [W-1:0] cs_unused;
      int n_unused;
      load_expected(cs_unused, n_unused);
    end
    done_cnt = 0;
    words_seen = 0;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (words_seen >= 2 && out_valid) break;
    end
    check("abort_reach", out_addr, 2);
    check("abort_cs_pre", checksum, 8'h11);
    @(posedge CLK); #3 init_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_cs", checksum, 0);
    repeat (2) @(negedge CLK);
    sb.delete();
    #2 init_n = 1'b1;
    repeat (5) @(negedge CLK);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);
    run_dump("after_abort", 0, 1'b0);

    // End register all ones, no wrap.
    for (int i = 0; i < N; i++) regs[i] = '0;
    regs[0] = 8'h01;
    regs[7] = 8'hFF;
    run_dump("edge", 0, 1'b0);
`ifndef REG_DUMP_SKIP_ZERO_EN
    check("edge_cs_const", checksum, 8'hFE);
`endif
    check("edge_last_addr", out_addr, 7);
    check("edge_last_data", out_data, 8'hFF);

    // All-zero dump.
    for (int i = 0; i < N; i++) regs[i] = '0;
    run_dump("zero", 0, 1'b0);

    // New contents between dumps.
    for (int i = 0; i < N; i++) regs[i] = W'($urandom_range(255, 1));
    run_dump("rand", 0, 1'b0);
    for (int i = 0; i < N; i++) regs[i] = W'($urandom_range(255, 0));
    run_dump("rand2", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
